// File: rtl/mem_stage_sram_ctrl.sv
// MEM-stage controller: splits each 32-bit load/store into two 16-bit SRAM accesses with wait states.
// Optional: define ADDR_RANGE_CHECK_EN to reject misaligned or out-of-range requests with an addr_err pulse.
module mem_stage_sram_ctrl #(
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int          SRAM_ADDR_W = 18,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic                   rd_en,
    input  logic [31:0]            address,
    input  logic [31:0]            st_val,
    output logic [31:0]            rd_data,
    output logic                   ready,
    output logic                   addr_err,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [15:0]            sram_dq_o,
    input  logic [15:0]            sram_dq_i,
    output logic                   sram_dq_oe,
    output logic                   sram_we_n,
    output logic [1:0]             dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [2:0] LAST_CNT = 3'(WAIT_CYCLES);

    state_t      r_state;
    state_t      w_next;
    logic [2:0]  r_wait_cnt;
    logic        r_is_wr;
    logic [31:0] r_rd_data;
    logic        r_addr_err;
    logic [31:0] w_word;
    logic        w_req;
    logic        w_fault;
    logic        w_last;

    assign w_word = (address - BASE_ADDR) >> 2;
    assign w_req  = rd_en | wr_en;
    assign w_last = (r_wait_cnt == LAST_CNT);

`ifdef ADDR_RANGE_CHECK_EN
    assign w_fault = w_req && ((address[1:0] != 2'b00) || (address < BASE_ADDR) ||
                               (w_word[31:SRAM_ADDR_W-1] != '0));
`else
    logic w_unused_bits;
    assign w_unused_bits = ^{w_word[31:SRAM_ADDR_W-1], address[1:0]};
    assign w_fault       = 1'b0;
`endif

    always_comb begin
        w_next     = r_state;
        ready      = 1'b0;
        sram_addr  = '0;
        sram_dq_o  = '0;
        sram_dq_oe = 1'b0;
        sram_we_n  = 1'b1;
        case (r_state)
            S_IDLE: begin
                ready = ~w_req | w_fault;
                if (w_req && !w_fault) w_next = S_LO;
            end
            S_LO: begin
                sram_addr = {w_word[SRAM_ADDR_W-2:0], 1'b0};
                if (r_is_wr) begin
                    sram_we_n  = 1'b0;
                    sram_dq_oe = 1'b1;
                    sram_dq_o  = st_val[15:0];
                end
                if (w_last) w_next = S_HI;
            end
            S_HI: begin
                sram_addr = {w_word[SRAM_ADDR_W-2:0], 1'b1};
                if (r_is_wr) begin
                    sram_we_n  = 1'b0;
                    sram_dq_oe = 1'b1;
                    sram_dq_o  = st_val[31:16];
                end
                if (w_last) w_next = S_DONE;
            end
            S_DONE: begin
                ready  = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        // While held in reset the pipeline only sees whether a request is pending.
        if (!rst) ready = ~w_req;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= 3'd0;
            r_is_wr    <= 1'b0;
            r_rd_data  <= 32'd0;
            r_addr_err <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_addr_err <= (r_state == S_IDLE) && w_fault;
            if (w_next != r_state) r_wait_cnt <= 3'd0;
            else if (r_state == S_LO || r_state == S_HI) r_wait_cnt <= r_wait_cnt + 3'd1;
            // Write wins when both enables are set, so rd_data is left alone.
            if (r_state == S_IDLE && w_next == S_LO) r_is_wr <= wr_en;
            if (r_state == S_LO && w_last && !r_is_wr) r_rd_data[15:0] <= sram_dq_i;
            if (r_state == S_HI && w_last && !r_is_wr) r_rd_data[31:16] <= sram_dq_i;
        end
    end

    assign rd_data   = r_rd_data;
    assign addr_err  = r_addr_err;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Bench for mem_stage_sram_ctrl: one instance with WAIT_CYCLES=1 and one with WAIT_CYCLES=0, each on its own SRAM model.
module tb_mem_stage_sram_ctrl;

  localparam int AW = 18;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          wr_en      [2];
  logic          rd_en      [2];
  logic [31:0]   address    [2];
  logic [31:0]   st_val     [2];
  logic [31:0]   rd_data    [2];
  logic          ready      [2];
  logic          addr_err   [2];
  logic [AW-1:0] sram_addr  [2];
  logic [15:0]   sram_dq_o  [2];
  logic [15:0]   sram_dq_i  [2];
  logic          sram_dq_oe [2];
  logic          sram_we_n  [2];
  logic [1:0]    dbg_state  [2];

  logic [15:0] mem0 [256];
  logic [15:0] mem1 [256];

  logic [31:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  logic [AW-1:0] lo_addr, hi_addr;

  mem_stage_sram_ctrl #(.BASE_ADDR(32'd1024), .SRAM_ADDR_W(AW), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en[0]), .rd_en(rd_en[0]), .address(address[0]),
    .st_val(st_val[0]), .rd_data(rd_data[0]), .ready(ready[0]), .addr_err(addr_err[0]),
    .sram_addr(sram_addr[0]), .sram_dq_o(sram_dq_o[0]), .sram_dq_i(sram_dq_i[0]),
    .sram_dq_oe(sram_dq_oe[0]), .sram_we_n(sram_we_n[0]), .dbg_state(dbg_state[0])
  );

  mem_stage_sram_ctrl #(.BASE_ADDR(32'd1024), .SRAM_ADDR_W(AW), .WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en[1]), .rd_en(rd_en[1]), .address(address[1]),
    .st_val(st_val[1]), .rd_data(rd_data[1]), .ready(ready[1]), .addr_err(addr_err[1]),
    .sram_addr(sram_addr[1]), .sram_dq_o(sram_dq_o[1]), .sram_dq_i(sram_dq_i[1]),
    .sram_dq_oe(sram_dq_oe[1]), .sram_we_n(sram_we_n[1]), .dbg_state(dbg_state[1])
  );

  // SRAM models: write when strobe low and bus driven; asynchronous read.
  always @(posedge clk) if (!sram_we_n[0] && sram_dq_oe[0]) mem0[sram_addr[0][7:0]] <= sram_dq_o[0];
  always @(posedge clk) if (!sram_we_n[1] && sram_dq_oe[1]) mem1[sram_addr[1][7:0]] <= sram_dq_o[1];
  assign sram_dq_i[0] = mem0[sram_addr[0][7:0]];
  assign sram_dq_i[1] = mem1[sram_addr[1][7:0]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one request right after a rising edge and follow it to its DONE cycle.
  task automatic access(input int d, input bit wr, input bit rd, input logic [31:0] a,
                        input logic [31:0] v, input logic [31:0] exp_rd);
    int n;
    int exp_freeze;
    bit done;
    logic [31:0] e;
    exp_freeze = (d == 0) ? 3 : 5;
    exp_q.push_back(exp_rd);
    wr_en[d] = wr; rd_en[d] = rd; address[d] = a; st_val[d] = v;
    n = 0;
    done = 1'b0;
    while (!done && n < 40) begin
      @(negedge clk);
      if (dbg_state[d] == 2'd1 || dbg_state[d] == 2'd2) begin
        if (dbg_state[d] == 2'd1) lo_addr = sram_addr[d];
        else hi_addr = sram_addr[d];
        chk("sram_we_n", sram_we_n[d], !wr);
        chk("sram_dq_oe", sram_dq_oe[d], wr);
        if (wr) chk("sram_dq_o", sram_dq_o[d], (dbg_state[d] == 2'd1) ? v[15:0] : v[31:16]);
      end
      if (ready[d]) begin
        done = 1'b1;
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $error("FAIL sb_underflow observed=empty expected=entry");
        end else begin
          e = exp_q.pop_front();
          chk("rd_data_done", rd_data[d], e);
        end
        chk("done_state", dbg_state[d], 2'd3);
      end else begin
        n++;
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      n_tests++; n_fail++;
      $error("FAIL ready_timeout observed=%0d expected=%0d", n, exp_freeze);
    end
    chk("freeze_cycles", n, exp_freeze);
    wr_en[d] = 1'b0; rd_en[d] = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      wr_en[d] = 1'b0; rd_en[d] = 1'b0; address[d] = 32'd0; st_val[d] = 32'd0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_ready", ready[d], 1'b1);
      chk("rst_rd_data", rd_data[d], 32'd0);
      chk("rst_we_n", sram_we_n[d], 1'b1);
      chk("rst_oe", sram_dq_oe[d], 1'b0);
      chk("rst_sram_addr", sram_addr[d], 0);
      chk("rst_state", dbg_state[d], 2'd0);
      chk("rst_addr_err", addr_err[d], 1'b0);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Store then load on the WAIT_CYCLES=1 instance.
    access(1, 1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 32'd0);
    chk("t1_sram0", mem1[0], 16'hBEEF);
    chk("t1_sram1", mem1[1], 16'hDEAD);
    access(1, 1'b0, 1'b1, 32'd1024, 32'd0, 32'hDEADBEEF);
    chk("t2_lo_addr", lo_addr, 0);
    chk("t2_hi_addr", hi_addr, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("t2_hold_idle", rd_data[1], 32'hDEADBEEF);
    access(1, 1'b1, 1'b0, 32'd1040, 32'h0BADF00D, 32'hDEADBEEF);
    chk("t2_sram8", mem1[8], 16'hF00D);
    chk("t2_sram9", mem1[9], 16'h0BAD);

    // Zero wait states: fill, then back-to-back loads.
    access(0, 1'b1, 1'b0, 32'd1028, 32'hA1B2C3D4, 32'd0);
    access(0, 1'b1, 1'b0, 32'd1032, 32'h11223344, 32'd0);
    access(0, 1'b0, 1'b1, 32'd1028, 32'd0, 32'hA1B2C3D4);
    chk("t3_lo_addr_a", lo_addr, 2);
    chk("t3_hi_addr_a", hi_addr, 3);
    access(0, 1'b0, 1'b1, 32'd1032, 32'd0, 32'h11223344);
    chk("t3_lo_addr_b", lo_addr, 4);
    chk("t3_hi_addr_b", hi_addr, 5);

    // Both enables: the store wins and load data stays put.
    access(0, 1'b1, 1'b1, 32'd1036, 32'h12345678, 32'h11223344);
    chk("t4_sram6", mem0[6], 16'h5678);
    chk("t4_sram7", mem0[7], 16'h1234);
    chk("t4_rd_hold", rd_data[0], 32'h11223344);

    // Reset asserted during the high half of a load.
    rd_en[1] = 1'b1; address[1] = 32'd1024;
    n = 0;
    while (dbg_state[1] != 2'd2 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t5_reached_hi", dbg_state[1], 2'd2);
    rst = 1'b0;
    @(negedge clk);
    chk("t5_state", dbg_state[1], 2'd0);
    chk("t5_rd_data", rd_data[1], 32'd0);
    chk("t5_rd_data_other", rd_data[0], 32'd0);
    chk("t5_we_n", sram_we_n[1], 1'b1);
    chk("t5_oe", sram_dq_oe[1], 1'b0);
    chk("t5_sram_addr", sram_addr[1], 0);
    chk("t5_ready", ready[1], 1'b0);
    rd_en[1] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    access(1, 1'b0, 1'b1, 32'd1024, 32'd0, 32'hDEADBEEF);

`ifdef ADDR_RANGE_CHECK_EN
    // Faulting loads: ready never drops, one-cycle addr_err, no SRAM activity.
    for (int k = 0; k < 2; k++) begin
      rd_en[1] = 1'b1; address[1] = (k == 0) ? 32'd1026 : 32'd1020;
      @(negedge clk);
      chk("t6_ready", ready[1], 1'b1);
      chk("t6_state", dbg_state[1], 2'd0);
      chk("t6_we_n", sram_we_n[1], 1'b1);
      chk("t6_err_before", addr_err[1], 1'b0);
      @(posedge clk); #1;
      rd_en[1] = 1'b0;
      @(negedge clk);
      chk("t6_err_pulse", addr_err[1], 1'b1);
      chk("t6_state_after", dbg_state[1], 2'd0);
      @(negedge clk);
      chk("t6_err_clear", addr_err[1], 1'b0);
      chk("t6_rd_hold", rd_data[1], 32'hDEADBEEF);
      @(posedge clk); #1;
    end
`else
    chk("addr_err_tied0", addr_err[1], 1'b0);
    chk("addr_err_tied0_b", addr_err[0], 1'b0);
`endif

    chk("sb_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
